// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline scoreboard issuing stall/bubble/flush/freeze; optional operand
// forwarding selects when FORWARDING_EN is defined.
module hazard_sequencer #(
    parameter int REG_W   = 4,
    parameter int MEM_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             id_mem_w_en,
    input  logic             exe_branch_taken,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_id,
    output logic             flush,
    output logic             freeze_all
`ifdef FORWARDING_EN
    ,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b
`endif
);
    localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [0:0] RUN = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;
    localparam logic [REG_W-1:0] PC_REG = REG_W'(15);

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             exe_v_q, exe_mem_q, mem_v_q;
    logic [REG_W-1:0] exe_dest_q, mem_dest_q;
    logic             exe_v_d, exe_mem_d, hz_exe, hz_mem, hazard;
`ifdef FORWARDING_EN
    logic             exe_ld_q, wb_v_q;
    logic [REG_W-1:0] wb_dest_q;
`endif

    function automatic logic hit(input logic v, input logic [REG_W-1:0] d, input logic [REG_W-1:0] r);
        return v && (d == r);
    endfunction

    assign hz_exe = id_valid & (hit(exe_v_q, exe_dest_q, id_src1) | (id_two_src & hit(exe_v_q, exe_dest_q, id_src2)));
    assign hz_mem = id_valid & (hit(mem_v_q, mem_dest_q, id_src1) | (id_two_src & hit(mem_v_q, mem_dest_q, id_src2)));

`ifdef FORWARDING_EN
    // Only a load still in EXE is too late to forward; everything else comes over the bypass.
    assign hazard    = hz_exe & exe_ld_q;
    assign fwd_sel_a = hit(mem_v_q, mem_dest_q, id_src1) ? 2'b01 :
                       hit(wb_v_q, wb_dest_q, id_src1) ? 2'b10 : 2'b00;
    assign fwd_sel_b = !id_two_src ? 2'b00 :
                       hit(mem_v_q, mem_dest_q, id_src2) ? 2'b01 :
                       hit(wb_v_q, wb_dest_q, id_src2) ? 2'b10 : 2'b00;
`else
    assign hazard = hz_exe | hz_mem;
`endif

    assign freeze_all = (state_q == WAIT);
    // Flush is gated by rst so every output reads 0 while reset is held.
    assign flush      = rst & exe_branch_taken & ~freeze_all;
    assign stall_if   = hazard & ~flush & ~freeze_all;
    assign stall_id   = stall_if;
    assign bubble_id  = stall_if;

    assign exe_v_d   = id_valid & id_wb_en & (id_dest != PC_REG) & ~bubble_id & ~flush;
    assign exe_mem_d = (id_mem_r_en | id_mem_w_en) & ~bubble_id & ~flush;

    assign state_d = freeze_all ? ((cnt_q == CW'(1)) ? RUN : WAIT)
                                : ((exe_mem_q && MEM_LAT != 0) ? WAIT : RUN);
    assign cnt_d   = freeze_all ? cnt_q - CW'(1) : (exe_mem_q ? CW'(MEM_LAT) : cnt_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            exe_v_q    <= 1'b0;
            exe_mem_q  <= 1'b0;
            exe_dest_q <= '0;
            mem_v_q    <= 1'b0;
            mem_dest_q <= '0;
`ifdef FORWARDING_EN
            exe_ld_q   <= 1'b0;
            wb_v_q     <= 1'b0;
            wb_dest_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!freeze_all) begin
                exe_v_q    <= exe_v_d;
                exe_mem_q  <= exe_mem_d;
                exe_dest_q <= id_dest;
                mem_v_q    <= exe_v_q;
                mem_dest_q <= exe_dest_q;
`ifdef FORWARDING_EN
                exe_ld_q   <= id_mem_r_en;
                wb_v_q     <= mem_v_q;
                wb_dest_q  <= mem_dest_q;
`endif
            end
        end
    end
endmodule
